// File: rtl/seg14_scan_decoder.sv
// seg14_scan_decoder
// Receive side of the 12-digit multiplexed 14-segment display path. Samples
// the scanned digit select and segment lines, recognises each glyph, rebuilds
// the 12-character frame and streams completed frames out as ASCII over a
// valid/ready interface. Assembly and streaming are double buffered.
// Optional feature macro: SEG14_FRAME_CONFIRM_EN -- a completed frame is only
// published when it is identical to the previously completed frame.
module seg14_scan_decoder #(
    parameter int NDIG = 12                 // fixed: sel_in width and frame length
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NDIG-1:0] sel_in,
    input  logic [13:0]     segm_in,
    output logic            char_valid,
    input  logic            char_ready,
    output logic [6:0]      char_data,
    output logic [3:0]      char_idx,
    output logic            char_last,
    output logic            frame_err,
    output logic            glyph_err,
    output logic            frame_drop
);

    localparam logic [3:0]      LAST_IDX   = 4'(NDIG - 1);
    localparam logic [6:0]      CH_SPACE   = 7'h20;
    localparam logic [6:0]      CH_UNKNOWN = 7'h3F;
    localparam logic [NDIG-1:0] SEL_ONE    = NDIG'(1);

    typedef enum logic {HUNT, ASSEMBLE} state_t;

    logic [NDIG-1:0]      sel_r;
    logic [13:0]          segm_r;
    logic [3:0]           sel_k;
    logic                 sel_none;
    logic                 sel_multi;
    logic [6:0]           glyph_ch;
    logic                 glyph_known;
    logic                 take;
    logic                 seq_err;
    logic                 frame_done;
    logic                 publish;
    state_t               state;
    logic [3:0]           prev_idx;
    logic [3:0]           exp_idx;
    logic [NDIG-1:0][6:0] asm_buf;
    logic [NDIG-1:0][6:0] done_frame;
    logic [NDIG-1:0][6:0] out_buf;
    logic [3:0]           rd_idx;
    logic                 accept;
    logic                 out_busy;

    // Register the display lines once; every decision below uses these copies.
    // NOTE: sequential state uses non-blocking assignments only, so each flop samples pre-edge values whatever the block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_r  <= '0;
            segm_r <= '0;
        end else begin
            sel_r  <= sel_in;
            segm_r <= segm_in;
        end
    end

    // Select decode: index of the set bit (meaningful only when exactly one is set).
    always_comb begin
        // NOTE: every variable of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        sel_k = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (sel_r[i]) sel_k = 4'(i);
        end
    end

    assign sel_none  = (sel_r == '0);
    assign sel_multi = ((sel_r & (sel_r - SEL_ONE)) != '0);

    // Glyph recognition on the registered segment pattern.
    always_comb begin
        glyph_ch    = CH_UNKNOWN;
        glyph_known = 1'b1;
        case (segm_r)
            14'b00000000000000: glyph_ch = 7'h20;
            14'b01100000001000: glyph_ch = 7'h31;
            14'b10001110000000: glyph_ch = 7'h46;
            14'b10111101000000: glyph_ch = 7'h47;
            14'b01101100101000: glyph_ch = 7'h4D;
            14'b11001111000000: glyph_ch = 7'h50;
            14'b01101100000101: glyph_ch = 7'h57;
            default:            glyph_known = 1'b0;
        endcase
    end

    // Classify the current sample: capture it, ignore it, or flag a sequence error.
    always_comb begin
        take    = 1'b0;
        seq_err = 1'b0;
        if (sel_multi) begin
            seq_err = 1'b1;
        end else if (!sel_none) begin
            if (state == HUNT) begin
                take = (sel_k == 4'd0);
            end else if (sel_k == prev_idx) begin
                take = 1'b0;                    // repeat scan of the same digit
            end else if (sel_k == exp_idx) begin
                take = 1'b1;
            end else begin
                seq_err = 1'b1;
                take    = (sel_k == 4'd0);      // a digit 0 restarts assembly at once
            end
        end
    end

    assign frame_done = take && (sel_k == LAST_IDX);

    // Assembly FSM: tracks the digit sequence and fills the assembly buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            prev_idx  <= '0;
            exp_idx   <= '0;
            // NOTE: the frame buffers are small flop arrays and reset to spaces so no stale text survives a reset; a RAM-style store would be left unreset.
            asm_buf   <= {NDIG{CH_SPACE}};
            frame_err <= 1'b0;
            glyph_err <= 1'b0;
        end else begin
            frame_err <= seq_err;
            glyph_err <= take && !glyph_known;
            if (take) begin
                asm_buf[sel_k] <= glyph_ch;
                prev_idx       <= sel_k;
                exp_idx        <= sel_k + 4'd1;
            end
            if (frame_done) begin
                state <= HUNT;
            end else if (take) begin
                state <= ASSEMBLE;
            end else if (seq_err) begin
                state <= HUNT;
            end
        end
    end

    // The completed frame includes the digit being captured this cycle.
    always_comb begin
        done_frame           = asm_buf;
        done_frame[LAST_IDX] = glyph_ch;
    end

`ifdef SEG14_FRAME_CONFIRM_EN
    logic [NDIG-1:0][6:0] last_frame;
    logic                 last_vld;

    // Remember every completed frame; only an exact repeat is published.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_frame <= {NDIG{CH_SPACE}};
            last_vld   <= 1'b0;
        end else if (frame_done) begin
            last_frame <= done_frame;
            last_vld   <= 1'b1;
        end
    end

    assign publish = frame_done && last_vld && (done_frame == last_frame);
`else
    assign publish = frame_done;
`endif

    // A frame arriving in the cycle index 11 is accepted still finds the streamer free.
    assign accept   = char_valid && char_ready;
    assign out_busy = char_valid && !(char_ready && (rd_idx == LAST_IDX));

    // Output streamer: load a published frame when free, then walk indices 0..11.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_buf    <= {NDIG{CH_SPACE}};
            rd_idx     <= '0;
            char_valid <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            frame_drop <= publish && out_busy;
            if (publish && !out_busy) begin
                out_buf    <= done_frame;
                rd_idx     <= '0;
                char_valid <= 1'b1;
            end else if (accept) begin
                if (rd_idx == LAST_IDX) begin
                    rd_idx     <= '0;
                    char_valid <= 1'b0;
                end else begin
                    rd_idx <= rd_idx + 4'd1;
                end
            end
        end
    end

    assign char_data = char_valid ? out_buf[rd_idx] : 7'h00;
    assign char_idx  = rd_idx;
    assign char_last = char_valid && (rd_idx == LAST_IDX);

endmodule

// File: tb/tb_seg14_scan_decoder.sv
// Self-checking bench for seg14_scan_decoder (default build). A frame-level
// reference model tracks the characters captured so far as a queue and
// predicts error pulses and the published character stream.
module tb_seg14_scan_decoder;

    localparam int NDIG = 12;

    typedef struct packed {
        logic [6:0] ch;
        logic [3:0] idx;
        logic       last;
    } item_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [NDIG-1:0] sel_in;
    logic [13:0]     segm_in;
    logic            char_valid;
    logic            char_ready;
    logic [6:0]      char_data;
    logic [3:0]      char_idx;
    logic            char_last;
    logic            frame_err;
    logic            glyph_err;
    logic            frame_drop;

    always #5 clk = ~clk;

    seg14_scan_decoder #(.NDIG(NDIG)) dut (
        .clk        (clk),
        .rst        (rst),
        .sel_in     (sel_in),
        .segm_in    (segm_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .char_data  (char_data),
        .char_idx   (char_idx),
        .char_last  (char_last),
        .frame_err  (frame_err),
        .glyph_err  (glyph_err),
        .frame_drop (frame_drop)
    );

    // Glyph table: index 0 sp, 1 '1', 2 F, 3 G, 4 M, 5 P, 6 W; 7 = unknown.
    logic [13:0] seg_tab [7] = '{14'b00000000000000, 14'b01100000001000, 14'b10001110000000,
                                 14'b10111101000000, 14'b01101100101000, 14'b11001111000000,
                                 14'b01101100000101};
    logic [6:0]  chr_tab [7] = '{7'h20, 7'h31, 7'h46, 7'h47, 7'h4D, 7'h50, 7'h57};

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int drops    = 0;

    logic [6:0] m_frame [$];
    item_t      exp_q [$];
    item_t      got_q [$];
    bit         m_publish = 1'b1;
    logic       ferr_pipe [2] = '{1'b0, 1'b0};
    logic       gerr_pipe [2] = '{1'b0, 1'b0};
    logic       rdy_want = 1'b1;
    logic       obs_valid = 1'b0;
    logic [3:0] obs_idx = '0;
    logic       hold_pending = 1'b0;
    logic [6:0] hold_ch = '0;
    logic [3:0] hold_idx = '0;

    int nominal [12] = '{3, 2, 4, 5, 6, 0, 1, 0, 0, 0, 0, 0};
    int unk4    [12] = '{6, 1, 2, 3, 7, 4, 5, 0, 1, 2, 3, 4};
    int all_w   [12] = '{6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph_of(input logic [13:0] g);
        for (int i = 0; i < 7; i++) if (seg_tab[i] == g) return chr_tab[i];
        return 7'h3F;
    endfunction

    function automatic logic [13:0] seg_for(input int gi);
        return (gi < 7) ? seg_tab[gi] : 14'h3FFF;
    endfunction

    // Frame-level model: a frame in progress is the queue of characters captured
    // so far; the next digit expected is its length, the last one seen is length-1.
    task automatic model_sample(input logic [11:0] s, input logic [13:0] g,
                                output logic fe, output logic ge);
        int ones;
        int k;
        fe   = 1'b0;
        ge   = 1'b0;
        ones = $countones(s);
        if (ones == 0) return;
        if (ones > 1) begin
            fe = 1'b1;
            m_frame.delete();
            return;
        end
        k = $clog2(s);
        if (m_frame.size() == 0) begin
            if (k != 0) return;
        end else if (k == m_frame.size() - 1) begin
            return;
        end else if (k != m_frame.size()) begin
            fe = 1'b1;
            m_frame.delete();
            if (k != 0) return;
        end
        m_frame.push_back(glyph_of(g));
        ge = (glyph_of(g) == 7'h3F);
        if (m_frame.size() == NDIG) begin
            if (m_publish)
                for (int i = 0; i < NDIG; i++)
                    exp_q.push_back(item_t'{m_frame[i], 4'(i), (i == NDIG - 1)});
            m_frame.delete();
        end
    endtask

    // One clock cycle: check and log outputs at the falling edge, then drive.
    task automatic step(input logic [11:0] s, input logic [13:0] g);
        logic fe, ge;
        @(negedge clk);
        check("frame_err", 32'(frame_err), 32'(ferr_pipe[1]));
        check("glyph_err", 32'(glyph_err), 32'(gerr_pipe[1]));
        if (frame_drop) drops++;
        if (hold_pending) begin
            check("hold valid", 32'(char_valid), 32'd1);
            check("hold data", 32'(char_data), 32'(hold_ch));
            check("hold idx", 32'(char_idx), 32'(hold_idx));
        end
        obs_valid  = char_valid;
        obs_idx    = char_idx;
        char_ready = rdy_want;
        if (char_valid && char_ready) got_q.push_back(item_t'{char_data, char_idx, char_last});
        hold_pending = char_valid && !char_ready;
        hold_ch      = char_data;
        hold_idx     = char_idx;
        model_sample(s, g, fe, ge);
        ferr_pipe[1] = ferr_pipe[0];
        ferr_pipe[0] = fe;
        gerr_pipe[1] = gerr_pipe[0];
        gerr_pipe[0] = ge;
        sel_in       = s;
        segm_in      = g;
    endtask

    task automatic send_digit(input int d, input int gi);
        step(12'b1 << d, seg_for(gi));
    endtask

    task automatic send_frame(input int gl [12]);
        for (int d = 0; d < NDIG; d++) send_digit(d, gl[d]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0);
    endtask

    task automatic compare_stream(input string tag);
        item_t e, g;
        check({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check({tag, " data"}, 32'(g.ch), 32'(e.ch));
            check({tag, " idx"}, 32'(g.idx), 32'(e.idx));
            check({tag, " last"}, 32'(g.last), 32'(e.last));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " valid"}, 32'(char_valid), 32'd0);
        check({tag, " data"}, 32'(char_data), 32'd0);
        check({tag, " idx"}, 32'(char_idx), 32'd0);
        check({tag, " last"}, 32'(char_last), 32'd0);
        check({tag, " frame_err"}, 32'(frame_err), 32'd0);
        check({tag, " glyph_err"}, 32'(glyph_err), 32'd0);
        check({tag, " frame_drop"}, 32'(frame_drop), 32'd0);
    endtask

    initial begin
        int drops_before;
        bit found;

        // Power-on reset.
        rst        = 1'b1;
        sel_in     = '0;
        segm_in    = '0;
        char_ready = 1'b1;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Nominal frame, valid rises two cycles after digit 11.
        send_frame(nominal);
        step('0, '0);
        check("valid before N+2", 32'(obs_valid), 32'd0);
        step('0, '0);
        check("valid at N+2", 32'(obs_valid), 32'd1);
        check("idx at N+2", 32'(obs_idx), 32'd0);
        idx_drain: idle(16);
        compare_stream("nominal");

        // Multi-hot select mid-frame, then a clean frame.
        for (int d = 0; d < 6; d++) send_digit(d, nominal[d]);
        step(12'b000000000011, seg_tab[0]);
        for (int d = 6; d < NDIG; d++) send_digit(d, nominal[d]);
        idle(16);
        compare_stream("bad select");
        send_frame(nominal);
        idle(16);
        compare_stream("after bad select");

        // Out of order 0,1,3: nothing published.
        send_digit(0, 3);
        send_digit(1, 2);
        for (int d = 3; d < NDIG; d++) send_digit(d, 4);
        idle(16);
        compare_stream("out of order");

        // Unknown glyph on digit 4.
        send_frame(unk4);
        idle(16);
        check("unknown idx4", (got_q.size() > 4) ? 32'(got_q[4].ch) : 32'd0, 32'h3F);
        compare_stream("unknown glyph");

        // Backpressure: ready low for 30 cycles after the first valid.
        drops_before = drops;
        rdy_want     = 1'b0;
        send_frame(nominal);
        m_publish = 1'b0;
        for (int c = 1; c <= 3 * NDIG; c++) begin
            if (c >= 32) rdy_want = 1'b1;
            send_digit((c - 1) % NDIG, all_w[(c - 1) % NDIG]);
        end
        rdy_want = 1'b1;
        idle(20);
        m_publish = 1'b1;
        check("frame_drop seen", 32'(drops > drops_before), 32'd1);
        compare_stream("backpressure");

        // Randomised scans with injected errors, ready held high.
        drops_before = drops;
        for (int f = 0; f < 24; f++) begin
            for (int d = 0; d < NDIG; d++) begin
                int gi;
                int reps;
                int a;
                logic [13:0] seg;
                gi   = $urandom_range(0, 7);
                seg  = (gi == 7) ? 14'($urandom) : seg_tab[gi];
                reps = $urandom_range(1, 2);
                a    = $urandom_range(0, NDIG - 1);
                case ($urandom_range(0, 23))
                    0: step((12'b1 << a) | (12'b1 << ((a + 1 + $urandom_range(0, 10)) % NDIG)), seg);
                    1: step(12'b1 << ((d + 2) % NDIG), seg);
                    2: step('0, 14'($urandom));
                    3: step(12'b1, seg);
                    default: ;
                endcase
                for (int r = 0; r < reps; r++) step(12'b1 << d, seg);
            end
        end
        idle(20);
        check("random no drops", 32'(drops), 32'(drops_before));
        compare_stream("random");

        // Reset asserted while index 5 is presented.
        send_frame(nominal);
        found = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            step('0, '0);
            if (obs_valid && obs_idx == 4'd4) found = 1'b1;
        end
        check("reached idx4", 32'(found), 32'd1);
        @(negedge clk);
        check("idx before reset", 32'(char_idx), 32'd5);
        rst     = 1'b1;
        sel_in  = '0;
        segm_in = '0;
        #1;
        check_outputs_zero("mid reset");
        while (exp_q.size() > got_q.size()) exp_q.delete(exp_q.size() - 1);
        compare_stream("pre reset");
        m_frame.delete();
        ferr_pipe    = '{1'b0, 1'b0};
        gerr_pipe    = '{1'b0, 1'b0};
        hold_pending = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int d = 6; d < NDIG; d++) send_digit(d, nominal[d]);
        idle(16);
        compare_stream("partial after reset");
        send_frame(unk4);
        idle(16);
        compare_stream("full after reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
